timer_motor_ctrl: RTL and testbench

TIMER_MOTOR_CTRL -- requirements
Module: timer_motor_ctrl

---
 rtl/timer_motor_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_timer_motor_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_motor_ctrl.sv
// Countdown timer with a two-field set mode, a pause sensor and a stepper-motor
// drive that runs only while the countdown is active.
module timer_motor_ctrl #(
  parameter int unsigned MIN_MAX   = 59,
  parameter int unsigned TICK_DIV  = 50,
  parameter int unsigned STEP_DIV  = 10,
  parameter int unsigned BLINK_DIV = 10,
  parameter int unsigned HALF_STEP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       start,
  input  logic       sensor,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [1:0] state_out,
  output logic       field_sel,
  output logic       blink,
  output logic [3:0] motor,
  output logic       done
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned StepW  = $clog2(STEP_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [StepW-1:0]  StepLast  = StepW'(STEP_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [5:0]        SecLast   = 6'd59;
  localparam logic [5:0]        MinLast   = 6'(MIN_MAX);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSet  = 2'b01,
    StRun  = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        sec_q, sec_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        psec_q, psec_d;
  logic [5:0]        pmin_q, pmin_d;
  logic              field_q, field_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]        phase_q, phase_d;
  logic              blink_q, blink_d;
  logic [3:0]        motor_q, motor_d;
  logic              done_q, done_d;
  logic [1:0]        rst_sync_q;
  logic              time_zero;
  logic              any_btn;

  function automatic logic [3:0] motor_code(input logic [2:0] ph);
    logic [3:0] code;
    code = 4'b0000;
    if (HALF_STEP != 0) begin
      case (ph)
        3'd0:    code = 4'b1000;
        3'd1:    code = 4'b1100;
        3'd2:    code = 4'b0100;
        3'd3:    code = 4'b0110;
        3'd4:    code = 4'b0010;
        3'd5:    code = 4'b0011;
        3'd6:    code = 4'b0001;
        default: code = 4'b1001;
      endcase
    end else begin
      case (ph[1:0])
        2'd0:    code = 4'b1000;
        2'd1:    code = 4'b0100;
        2'd2:    code = 4'b0010;
        default: code = 4'b0001;
      endcase
    end
    return code;
  endfunction

  // Reset asserts asynchronously; release is held off for two edges so the first
  // edge after deassertion never changes state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    psec_d      = psec_q;
    pmin_d      = pmin_q;
    field_d     = field_q;
    tick_cnt_d  = tick_cnt_q;
    step_cnt_d  = step_cnt_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    time_zero   = (sec_q == 6'd0) && (min_q == 6'd0);
    any_btn     = btn_mode | btn_inc | btn_dec | start;

    unique case (state_q)
      StIdle: begin
        if (btn_mode) begin
          state_d = StSet;
          field_d = 1'b0;
        end else if (start && !time_zero) begin
          psec_d     = sec_q;
          pmin_d     = min_q;
          tick_cnt_d = '0;
          step_cnt_d = '0;
          phase_d    = 3'd0;
          state_d    = StRun;
        end
      end
      StSet: begin
        if (btn_mode) begin
          if (field_q) begin
            state_d = StIdle;
            field_d = 1'b0;
          end else begin
            field_d = 1'b1;
          end
        end else if (btn_inc ^ btn_dec) begin
          if (!field_q) begin
            if (btn_inc) sec_d = (sec_q >= SecLast) ? 6'd0 : sec_q + 6'd1;
            else         sec_d = (sec_q == 6'd0) ? SecLast : sec_q - 6'd1;
          end else begin
            if (btn_inc) min_d = (min_q >= MinLast) ? 6'd0 : min_q + 6'd1;
            else         min_d = (min_q == 6'd0) ? MinLast : min_q - 6'd1;
          end
        end
      end
      StRun: begin
        if (start) begin
          state_d = StIdle;
        end else if (!sensor) begin
          if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else if (min_q != 6'd0) begin
              sec_d = SecLast;
              min_d = min_q - 6'd1;
            end
            if ((min_q == 6'd0) && (sec_q <= 6'd1)) state_d = StDone;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (step_cnt_q == StepLast) begin
            step_cnt_d = '0;
            phase_d    = (HALF_STEP != 0) ? phase_q + 3'd1 : {1'b0, phase_q[1:0] + 2'd1};
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (any_btn) begin
          sec_d   = psec_q;
          min_d   = pmin_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if ((state_q == StSet) || (state_q == StDone)) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end

    motor_d = ((state_d == StRun) && !sensor) ? motor_code(phase_d) : 4'b0000;
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      psec_q      <= 6'd0;
      pmin_q      <= 6'd0;
      field_q     <= 1'b0;
      tick_cnt_q  <= '0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 3'd0;
      blink_q     <= 1'b0;
      motor_q     <= 4'b0000;
      done_q      <= 1'b0;
    end else if (rst_sync_q[1]) begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      psec_q      <= psec_d;
      pmin_q      <= pmin_d;
      field_q     <= field_d;
      tick_cnt_q  <= tick_cnt_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
      motor_q     <= motor_d;
      done_q      <= done_d;
    end
  end

  assign sec_out   = sec_q;
  assign min_out   = min_q;
  assign state_out = state_q;
  assign field_sel = field_q;
  assign blink     = blink_q;
  assign motor     = motor_q;
  assign done      = done_q;

endmodule

// File: tb/tb_timer_motor_ctrl.sv
// Self-checking bench for timer_motor_ctrl: a full-step instance with default limits and a
// half-step instance with MIN_MAX=9 share one stimulus stream.
module tb_timer_motor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec, start, sensor;
  logic [5:0] sec_out, min_out, sec_h, min_h;
  logic [1:0] state_out, state_h;
  logic       field_sel, field_h, blink, blink_h, done, done_h;
  logic [3:0] motor, motor_h;

  always #5 clk = ~clk;

  timer_motor_ctrl #(
    .MIN_MAX(59), .TICK_DIV(50), .STEP_DIV(10), .BLINK_DIV(10), .HALF_STEP(0)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .start(start), .sensor(sensor), .sec_out(sec_out), .min_out(min_out),
    .state_out(state_out), .field_sel(field_sel), .blink(blink), .motor(motor), .done(done)
  );

  timer_motor_ctrl #(
    .MIN_MAX(9), .TICK_DIV(50), .STEP_DIV(10), .BLINK_DIV(10), .HALF_STEP(1)
  ) dut_h (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .start(start), .sensor(sensor), .sec_out(sec_h), .min_out(min_h),
    .state_out(state_h), .field_sel(field_h), .blink(blink_h), .motor(motor_h), .done(done_h)
  );

  typedef enum int {
    SelState, SelField, SelSec, SelMin, SelBlink, SelMotor, SelDone, SelMinH, SelMotorH
  } sel_e;

  typedef struct {
    sel_e  sel;
    int    exp;
    string name;
  } exp_t;

  typedef struct {
    logic m, i, d, s;
    int   st, fld, sc, mn, mnh, bl;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[16];
  logic [3:0] full_seq[4];
  logic [3:0] half_seq[8];
  int         checks = 0;
  int         failures = 0;

  function automatic int sig(sel_e s);
    case (s)
      SelState:  return int'(state_out);
      SelField:  return int'(field_sel);
      SelSec:    return int'(sec_out);
      SelMin:    return int'(min_out);
      SelBlink:  return int'(blink);
      SelMotor:  return int'(motor);
      SelDone:   return int'(done);
      SelMinH:   return int'(min_h);
      default:   return int'(motor_h);
    endcase
  endfunction

  task automatic expect_sig(input sel_e s, input int v, input string nm);
    exp_t e;
    e.sel  = s;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (sig(e.sel) != e.exp) begin
        failures++;
        $display("FAIL %s: got %0d, expected %0d", e.name, sig(e.sel), e.exp);
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    full_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    half_seq = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    //          m     i     d     s     st fld sec min minh blink
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0,  0,  0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0,  0,  0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 59, 0,  0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0,  0,  0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1,  0,  0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 2,  0,  0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 3,  0,  0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 4,  0,  0, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 5,  0,  0, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 5,  0,  0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 5,  0,  0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 5,  0,  0, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 5,  59, 9, 1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 5,  0,  0, 1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 5,  1,  1, 1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 5,  1,  1, 0};

    reset = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; start = 1'b0; sensor = 1'b0;
    #12;
    expect_sig(SelState, 0, "rst_state");
    expect_sig(SelSec, 0, "rst_sec");
    expect_sig(SelMin, 0, "rst_min");
    expect_sig(SelField, 0, "rst_field");
    expect_sig(SelBlink, 0, "rst_blink");
    expect_sig(SelMotor, 0, "rst_motor");
    expect_sig(SelDone, 0, "rst_done");
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) tick_clk();

    // Set mode: wrap-around, input priority and blink in SET
    for (int k = 0; k < 16; k++) begin
      btn_mode = vecs[k].m; btn_inc = vecs[k].i; btn_dec = vecs[k].d; start = vecs[k].s;
      expect_sig(SelState, vecs[k].st, $sformatf("set_state[%0d]", k));
      expect_sig(SelField, vecs[k].fld, $sformatf("set_field[%0d]", k));
      expect_sig(SelSec, vecs[k].sc, $sformatf("set_sec[%0d]", k));
      expect_sig(SelMin, vecs[k].mn, $sformatf("set_min[%0d]", k));
      expect_sig(SelMinH, vecs[k].mnh, $sformatf("set_min_h[%0d]", k));
      expect_sig(SelBlink, vecs[k].bl, $sformatf("set_blink[%0d]", k));
      tick_clk();
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; start = 1'b0;
    end

    // Run 01:05 to expiry with a 37-cycle pause starting 80 cycles in
    start = 1'b1;
    expect_sig(SelState, 2, "run_enter_state");
    expect_sig(SelMotor, 8, "run_enter_motor");
    expect_sig(SelMotorH, 8, "run_enter_motor_h");
    tick_clk();
    start = 1'b0;
    for (int n = 1; n <= 3287; n++) begin
      sensor = (n >= 81) && (n <= 117);
      if ((n % 10 == 0) && (n <= 80)) begin
        expect_sig(SelMotor, int'(full_seq[(n / 10) % 4]), $sformatf("full_step@%0d", n));
        expect_sig(SelMotorH, int'(half_seq[(n / 10) % 8]), $sformatf("half_step@%0d", n));
      end
      case (n)
        49:   expect_sig(SelSec, 5, "tick_not_yet");
        50:   begin expect_sig(SelSec, 4, "first_tick_sec"); expect_sig(SelMin, 1, "first_tick_min"); end
        81:   begin expect_sig(SelMotor, 0, "pause_motor"); expect_sig(SelMotorH, 0, "pause_motor_h"); end
        100:  begin expect_sig(SelSec, 4, "pause_sec_hold"); expect_sig(SelBlink, 0, "run_blink"); end
        117:  begin expect_sig(SelMotor, 0, "pause_motor_end"); expect_sig(SelState, 2, "pause_state"); end
        126:  begin expect_sig(SelMotor, 8, "resume_phase0"); expect_sig(SelMotorH, 8, "resume_phase0_h"); end
        127:  begin expect_sig(SelMotor, 4, "resume_phase1"); expect_sig(SelMotorH, 12, "resume_phase1_h"); end
        136:  expect_sig(SelSec, 4, "resumed_tick_not_yet");
        137:  expect_sig(SelSec, 3, "resumed_tick");
        336:  begin expect_sig(SelSec, 0, "pre_borrow_sec"); expect_sig(SelMin, 1, "pre_borrow_min"); end
        337:  begin expect_sig(SelSec, 59, "borrow_sec"); expect_sig(SelMin, 0, "borrow_min"); end
        3286: begin
          expect_sig(SelState, 2, "pre_done_state");
          expect_sig(SelSec, 1, "pre_done_sec");
          expect_sig(SelDone, 0, "pre_done_flag");
        end
        3287: begin
          expect_sig(SelState, 3, "done_state");
          expect_sig(SelSec, 0, "done_sec");
          expect_sig(SelMin, 0, "done_min");
          expect_sig(SelDone, 1, "done_flag");
          expect_sig(SelMotor, 0, "done_motor");
        end
        default: ;
      endcase
      tick_clk();
    end
    sensor = 1'b0;

    // DONE: blink, then any button reloads the preset
    for (int d = 1; d <= 10; d++) begin
      if (d == 9) expect_sig(SelBlink, 0, "done_blink_low");
      if (d == 10) begin
        expect_sig(SelBlink, 1, "done_blink_toggle");
        expect_sig(SelState, 3, "done_hold");
      end
      tick_clk();
    end
    btn_inc = 1'b1;
    expect_sig(SelState, 0, "reload_state");
    expect_sig(SelSec, 5, "reload_sec");
    expect_sig(SelMin, 1, "reload_min");
    expect_sig(SelDone, 0, "reload_done");
    expect_sig(SelBlink, 0, "reload_blink");
    tick_clk();
    btn_inc = 1'b0;

    // Cancel on the tick cycle keeps the undecremented time
    start = 1'b1;
    expect_sig(SelState, 2, "cancel_run_state");
    tick_clk();
    start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      start = (n == 50);
      if (n == 49) expect_sig(SelState, 2, "cancel_pre_state");
      if (n == 50) begin
        expect_sig(SelState, 0, "cancel_state");
        expect_sig(SelSec, 5, "cancel_sec");
        expect_sig(SelMin, 1, "cancel_min");
        expect_sig(SelMotor, 0, "cancel_motor");
      end
      tick_clk();
    end
    start = 1'b0;

    // Asynchronous reset mid-RUN, then the first edge after release is ignored
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 15) expect_sig(SelMotor, 4, "pre_reset_motor");
      tick_clk();
    end
    #2;
    reset = 1'b0;
    #1;
    expect_sig(SelState, 0, "async_rst_state");
    expect_sig(SelSec, 0, "async_rst_sec");
    expect_sig(SelMin, 0, "async_rst_min");
    expect_sig(SelMotor, 0, "async_rst_motor");
    expect_sig(SelMotorH, 0, "async_rst_motor_h");
    expect_sig(SelDone, 0, "async_rst_done");
    expect_sig(SelBlink, 0, "async_rst_blink");
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    btn_mode = 1'b1;
    expect_sig(SelState, 0, "release_edge_ignored");
    tick_clk();
    btn_mode = 1'b0;
    tick_clk();
    tick_clk();
    btn_mode = 1'b1;
    expect_sig(SelState, 1, "post_release_mode");
    tick_clk();
    btn_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
